// File: rtl/enigma_pkg.sv
// Shared types and helpers for the rotor letter path: 5-bit letter indices
// in the range 0-25 and the stepping controller state.
package enigma_pkg;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } step_state_t;

  localparam letter_t LAST_LETTER = letter_t'(NUM_LETTERS - 1);

  // Maps any 5-bit code onto a legal letter; 26..31 fold to 0..5.
  function automatic letter_t reduce_letter(input letter_t v);
    return (v > LAST_LETTER) ? letter_t'(v - letter_t'(NUM_LETTERS)) : v;
  endfunction

endpackage

// File: rtl/rotor_incr.sv
// Single-rotor incrementer: next position modulo 26 when stepping, plus the
// notch and wrap equality flags for the current position.
module rotor_incr
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH = '0
) (
  input  letter_t cur,
  input  logic    step,
  output letter_t nxt,
  output logic    at_notch,
  output logic    wrap
);

  assign wrap     = (cur == LAST_LETTER);
  assign at_notch = (cur == NOTCH);
  assign nxt      = !step ? cur : (wrap ? letter_t'(0) : letter_t'(cur + letter_t'(1)));

endmodule

// File: rtl/rotor_step_ctrl.sv
// Three-rotor stepping controller: load with modulo-26 reduction, one step
// per accepted keypress with Enigma turnover and middle-rotor double step.
module rotor_step_ctrl
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH_R = 5'd21,
  parameter letter_t NOTCH_M = 5'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] pos_in_l,
  input  logic [4:0] pos_in_m,
  input  logic [4:0] pos_in_r,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic       step_done,
  output logic       load_err
);

  step_state_t state;
  letter_t     nxt_l, nxt_m, nxt_r;
  logic        notch_m_hit, notch_r_hit;
  logic [2:0]  unused_wrap;
  logic        unused_notch_l;

  // The middle rotor also steps on its own notch: this is the double step.
  rotor_incr #(.NOTCH(NOTCH_R)) u_incr_r (
    .cur(pos_r), .step(1'b1), .nxt(nxt_r), .at_notch(notch_r_hit), .wrap(unused_wrap[0])
  );
  rotor_incr #(.NOTCH(NOTCH_M)) u_incr_m (
    .cur(pos_m), .step(notch_r_hit | notch_m_hit), .nxt(nxt_m), .at_notch(notch_m_hit),
    .wrap(unused_wrap[1])
  );
  rotor_incr #(.NOTCH(letter_t'(0))) u_incr_l (
    .cur(pos_l), .step(notch_m_hit), .nxt(nxt_l), .at_notch(unused_notch_l),
    .wrap(unused_wrap[2])
  );

  // NOTE: state registers use non-blocking assignments so every update in
  // this block sees the pre-edge positions, matching the stepping rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pos_l     <= '0;
      pos_m     <= '0;
      pos_r     <= '0;
      key_ready <= 1'b1;
      step_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (load) begin
      state     <= IDLE;
      pos_l     <= reduce_letter(pos_in_l);
      pos_m     <= reduce_letter(pos_in_m);
      pos_r     <= reduce_letter(pos_in_r);
      load_err  <= (pos_in_l > LAST_LETTER) | (pos_in_m > LAST_LETTER) |
                   (pos_in_r > LAST_LETTER);
      key_ready <= 1'b1;
      step_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            state     <= HOLD;
            pos_l     <= nxt_l;
            pos_m     <= nxt_m;
            pos_r     <= nxt_r;
            key_ready <= 1'b0;
            step_done <= 1'b1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          key_ready <= 1'b1;
          step_done <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b1;
          step_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rotor_step_ctrl.md
# rotor_step_ctrl

Stepping controller for the three-rotor letter path. It holds the left, middle and right rotor positions as letter indices 0–25. On each accepted keypress it advances them using Enigma turnover rules, including the middle-rotor double step. Position outputs feed the rotor substitution datapath, and the per-rotor wrap/notch equality tests drive all stepping decisions.

## Interface
- NOTCH_R, 21: right-rotor position (0–25) that makes the middle rotor step on the next keypress.
- NOTCH_M, 4: middle-rotor position (0–25) that makes the middle and left rotors step on the next keypress.
- CLK input 1: single clock; all state updates on rising edge.
- RST_N input 1: reset is asynchronous and active-low.
- LOAD input 1: load the initial positions from POS_IN_*; highest priority.
- POS_IN_L / POS_IN_M / POS_IN_R input 5 each: initial positions, sampled when LOAD=1.
- KEY_VALID input 1: keypress request; held until accepted.
- KEY_READY output 1: controller can accept a keypress this cycle.
- POS_L / POS_M / POS_R output 5 each: current rotor positions, registered, always 0–25.
- STEP_DONE output 1: one-cycle pulse; positions reflect the just-accepted keypress.
- LOAD_ERR output 1: sticky flag; the last load contained a value above 25.

## Operation
- FSM states:
  - IDLE: KEY_READY=1.
  - HOLD: KEY_READY=0, STEP_DONE=1.
- Reset (async, RST_N=0): state IDLE, POS_L/M/R=0, STEP_DONE=0, LOAD_ERR=0, KEY_READY=1 once RST_N releases.
- LOAD=1 in any state:
  - Each POS_IN_x is reduced modulo 26 (values 26–31 map to 0–5) and written to POS_x.
  - LOAD_ERR is set to 1 if any input exceeded 25, otherwise cleared.
  - Next state is IDLE. STEP_DONE is 0 next cycle.
  - A simultaneous KEY_VALID is not accepted.
- In IDLE, when KEY_VALID=1 and LOAD=0, the keypress is accepted. Stepping uses the pre-step positions:
  - Right rotor always steps.
  - Middle rotor steps if POS_R==NOTCH_R or POS_M==NOTCH_M (double step).
  - Left rotor steps if POS_M==NOTCH_M.
  - Next state is HOLD.
- Increment rule: 25 → 0, otherwise +1. All arithmetic is 5-bit and results never exceed 25.
- HOLD always returns to IDLE after one cycle, unless LOAD is asserted, in which case the load applies.
- KEY_VALID in HOLD is ignored. The requester keeps it asserted until it sees KEY_READY=1.

## Timing
- Accept edge: at the rising edge with IDLE·KEY_VALID·¬LOAD, the new positions are registered. They are visible in the following cycle, which is the HOLD cycle with STEP_DONE=1.
- Latency from accept to valid positions is 1 cycle. Throughput is 1 keypress per 2 cycles.
- Load latency is 1 cycle: POS_x is valid the cycle after the LOAD edge.
- Holding KEY_VALID high continuously steps once every 2 cycles.
- Reset mid-HOLD clears STEP_DONE immediately (asynchronously). No pending step survives reset.

## Structure
- Shared package enigma_pkg:
  - LETTER_W=5 and NUM_LETTERS=26.
  - typedef letter_t, a 5-bit logic.
  - enum step_state_t {IDLE, HOLD}.
- Sub-module rotor_incr, instantiated once per rotor:
  - Inputs: letter_t, step enable.
  - Outputs: next letter (mod 26), at_notch (equality against a NOTCH parameter), wrap (current==25).
- The top level holds the FSM, the position registers, the load reduction and LOAD_ERR.

## Test plan
- Reset with RST_N=0 asynchronously mid-cycle → POS=(0,0,0), KEY_READY=1 after release, STEP_DONE=0, LOAD_ERR=0.
- Load (0,3,20), then 3 keypresses → positions (0,3,21), (0,4,22), (1,5,23) (double step), with exactly one STEP_DONE pulse per key.
- Load (25,25,25), then 1 keypress → (25,25,0), since M≠NOTCH_M and R≠NOTCH_R, so only the right rotor steps with wrap. Load (25,4,25), then 1 keypress → (0,5,0).
- Load (30,26,7) → POS=(4,0,7), LOAD_ERR=1. A following load of (1,2,3) → LOAD_ERR=0.
- Hold KEY_VALID=1 for 10 cycles from (0,0,0) → 5 acceptances and POS_R=5. KEY_READY and STEP_DONE alternate, never both high.
- LOAD and KEY_VALID asserted on the same IDLE cycle → the load wins, no step occurs, and STEP_DONE stays 0. LOAD asserted during HOLD → the load applies and the state returns to IDLE.
